// File: rtl/uc_pkg.sv
// Shared types and sizing constants for the sweep controller.
package uc_pkg;

  localparam int UC_WIDTH = 4;
  localparam int UC_CYC_W = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } uc_state_e;

endpackage

// File: rtl/uc_sweep_ctrl.sv
// Triangle-sweep controller driving an external up/down counter between lo and hi.
// Optional pause input is enabled by defining UC_SWEEP_PAUSE_EN.
module uc_sweep_ctrl
  import uc_pkg::*;
#(
  parameter int WIDTH = UC_WIDTH
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    lo,
  input  logic [WIDTH-1:0]    hi,
  input  logic [UC_CYC_W-1:0] cycles,
  input  logic [WIDTH-1:0]    q,
`ifdef UC_SWEEP_PAUSE_EN
  input  logic                pause,
`endif
  output logic                load,
  output logic [WIDTH-1:0]    data,
  output logic                up_down,
  output logic                en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  uc_state_e           state;
  logic [WIDTH-1:0]    lo_reg;
  logic [WIDTH-1:0]    hi_reg;
  logic [UC_CYC_W-1:0] cyc_reg;
  logic                bad_reg;
  logic                hold;

`ifdef UC_SWEEP_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= S_IDLE;
      lo_reg  <= '0;
      hi_reg  <= '0;
      cyc_reg <= '0;
      bad_reg <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      state   <= S_IDLE;
      bad_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lo_reg  <= lo;
            hi_reg  <= hi;
            cyc_reg <= cycles;
            bad_reg <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (hi_reg <= lo_reg) begin
            bad_reg <= 1'b1;
            state   <= S_DONE;
          end else if (cyc_reg == '0) begin
            state <= S_DONE;
          end else begin
            state <= S_UP;
          end
        end
        S_UP: begin
          if (!hold && q == hi_reg) state <= S_DOWN;
        end
        S_DOWN: begin
          // cyc_reg is non-zero here because LOAD filtered the zero case.
          if (!hold && q == lo_reg && cyc_reg != '0) begin
            cyc_reg <= cyc_reg - 1'b1;
            state   <= (cyc_reg == 1) ? S_DONE : S_UP;
          end
        end
        S_DONE: begin
          bad_reg <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != S_IDLE);
    load    = (state == S_LOAD) && !abort;
    data    = (state == S_LOAD) ? lo_reg : '0;
    up_down = (state == S_UP);
    en      = 1'b0;
    if (!abort && !hold) begin
      if (state == S_UP)   en = (q != hi_reg);
      if (state == S_DOWN) en = (q != lo_reg);
    end
    done    = (state == S_DONE);
    err     = (state == S_DONE) && bad_reg;
  end

endmodule

// File: tb/tb_uc_sweep_ctrl.sv
// Bench: sweep controller closed-loop with a 4-bit universal counter; scoreboard of q samples.
module tb_uc_sweep_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] lo = '0;
  logic [W-1:0] hi = '0;
  logic [3:0]   cycles = '0;
  logic [W-1:0] q;
  logic         load, up_down, en, busy, done, err;
  logic [W-1:0] data;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  bit sb_on = 1'b1;
  int done_cnt, err_cnt, en_cnt;

  always #5 clk = ~clk;

  uc_sweep_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .cycles(cycles), .q(q),
`ifdef UC_SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .load(load), .data(data), .up_down(up_down), .en(en),
    .busy(busy), .done(done), .err(err)
  );

  // Universal up/down counter with synchronous load closing the q loop.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n)       q <= '0;
    else if (load)    q <= data;
    else if (en)      q <= up_down ? q + 1'b1 : q - 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Counter samples while the sweep is moving (not LOAD/DONE, not paused).
  always @(negedge clk) begin
    if (clr_n) begin
      if (sb_on && busy && !load && !done && !pause) begin
        if (exp_q.size() == 0) check("q_extra", 32'(q), 32'hffff);
        else check("q", 32'(q), 32'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (en && busy) en_cnt++;
    end
  end

  task automatic run_job(input int l, input int h, input int c, input bit glitch, input bit do_pause);
    bit exp_err;
    bit hit;
    exp_err = (h <= l);
    if (!exp_err) begin
      for (int k = 0; k < c; k++) begin
        for (int v = l; v <= h; v++) exp_q.push_back(W'(v));
        for (int v = h; v >= l; v--) exp_q.push_back(W'(v));
      end
    end
    done_cnt = 0; err_cnt = 0; en_cnt = 0;
    @(posedge clk); #1;
    lo = W'(l); hi = W'(h); cycles = 4'(c); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lo = W'($urandom_range(0, 15)); hi = W'($urandom_range(0, 15));
    cycles = 4'($urandom_range(0, 15));
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (glitch && i == 3) begin
        lo = '0; hi = 4'hf; cycles = 4'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
`ifdef UC_SWEEP_PAUSE_EN
      if (do_pause && i == 4) begin
        logic [W-1:0] held;
        pause = 1'b1;
        held = q;
        repeat (3) begin
          @(posedge clk); #1;
          check("pause_hold", 32'(q), 32'(held));
          check("pause_en", 32'(en), 32'd0);
        end
        pause = 1'b0;
      end
`endif
      @(posedge clk); #1;
      if (done_cnt > 0) begin
        hit = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(hit), 32'd1);
    check("busy_fall", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("done_once", 32'(done_cnt), 32'd1);
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
    check("q_final", 32'(q), 32'(l));
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    if (exp_err || c == 0) check("en_idle", 32'(en_cnt), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit hit;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {25'd0, load, data, up_down, en, done, err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;

    run_job(2, 5, 1, 1'b1, 1'b0);
    run_job(0, 15, 2, 1'b0, 1'b1);
    run_job(7, 7, 3, 1'b0, 1'b0);
    run_job(9, 3, 1, 1'b0, 1'b0);
    run_job(4, 8, 0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      int a, b;
      a = $urandom_range(0, 13);
      b = $urandom_range(a + 1, 15);
      run_job(a, b, $urandom_range(1, 3), 1'b0, 1'b1);
    end

    // Abort on the way down at q=6.
    sb_on = 1'b0; done_cnt = 0;
    @(posedge clk); #1;
    lo = 4'd3; hi = 4'd8; cycles = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy && !load && !done && !up_down && q == 4'd6) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reach", 32'(hit), 32'd1);
    check("pre_abort_en", 32'(en), 32'd1);
    abort = 1'b1;
    #1;
    check("abort_en", 32'(en), 32'd0);
    check("abort_load", 32'(load), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_q", 32'(q), 32'd6);
    repeat (3) @(posedge clk);
    #1 check("abort_nodone", 32'(done_cnt), 32'd0);

    // Reset mid-UP discards the job.
    done_cnt = 0;
    lo = 4'd1; hi = 4'd14; cycles = 4'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("pre_rst_up", 32'(up_down & en), 32'd1);
    clr_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_outs", {25'd0, load, data, up_down, en, done, err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_nodone", 32'(done_cnt), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);
    sb_on = 1'b1;

    run_job(2, 5, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
